direction_encoder: RTL and testbench

Converts the four raw player push-buttons into the registered 3-bit snake direction code consumed by the direction decoder. The code is 0 = right, 1 = left, 2 = up, 3 = down. Each button is synchronized and debounced, and its press is captured as a pending request. The request is committed only on the game-step strobe, so the snake turns at most once per step. This block sits between the board buttons and the movement/decoder logic.

---
 rtl/direction_encoder_if.sv | 14 +
 rtl/direction_encoder.sv | 75 +++++++
 tb/tb_direction_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/direction_encoder_if.sv
// direction_encoder_if: raw buttons and step strobe in; committed direction, change pulse and pending flag out.
// master drives btn_r/btn_l/btn_u/btn_d/tick and reads dir/dir_changed/pending; slave is the encoder side.
interface direction_encoder_if;
    logic       btn_r;
    logic       btn_l;
    logic       btn_u;
    logic       btn_d;
    logic       tick;
    logic [2:0] dir;
    logic       dir_changed;
    logic       pending;
    modport master (output btn_r, btn_l, btn_u, btn_d, tick, input dir, dir_changed, pending);
    modport slave (input btn_r, btn_l, btn_u, btn_d, tick, output dir, dir_changed, pending);
endinterface

// File: rtl/direction_encoder.sv
// direction_encoder: synchronizes and debounces four buttons, captures one press and commits it as the snake direction on tick.
// Ports: clk, rst_n (async active-low), bus (slave: btn_r/l/u/d, tick in; dir, dir_changed, pending out).
// Optional DIR_REVERSE_LOCK_EN rejects 180-degree reversals at commit.
module direction_encoder #(
    parameter int DEB_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    direction_encoder_if.slave   bus
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    typedef enum logic {IDLE, PEND} state_t;
    // bit index equals the direction code: 0 right, 1 left, 2 up, 3 down
    logic [3:0]         raw;
    logic [3:0]         s1_q, s_q, db_q, db_d, db_dly_q, press;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [1:0]         pend_q, pend_d, press_code;
    logic [2:0]         dir_q, dir_d;
    logic               chg_q, single, commit_en, opposite, lock_blk, upd;
    assign raw = {bus.btn_d, bus.btn_u, bus.btn_l, bus.btn_r};
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (s_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) db_d[i] = s_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
    assign press      = db_q & ~db_dly_q;
    assign single     = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
    assign press_code = press[3] ? 2'd3 : press[2] ? 2'd2 : press[1] ? 2'd1 : 2'd0;
    assign commit_en  = bus.tick && (state_q == PEND);
    // opposite pairs share bit 1 and differ in bit 0
    assign opposite   = (pend_q[1] == dir_q[1]) && (pend_q[0] != dir_q[0]);
`ifdef DIR_REVERSE_LOCK_EN
    assign lock_blk   = opposite;
`else
    assign lock_blk   = 1'b0;
`endif
    assign upd        = commit_en && (pend_q != dir_q[1:0]) && !lock_blk;
    always_comb begin
        state_d = single ? PEND : commit_en ? IDLE : state_q;
        pend_d  = single ? press_code : pend_q;
        dir_d   = upd ? {1'b0, pend_q} : dir_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s_q      <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            pend_q   <= '0;
            dir_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            s1_q     <= raw;
            s_q      <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            chg_q    <= upd;
        end
    end
    assign bus.dir         = dir_q;
    assign bus.dir_changed = chg_q;
    assign bus.pending     = (state_q == PEND);
endmodule

// File: tb/tb_direction_encoder.sv
// tb_direction_encoder: directed table and corner sequences for direction_encoder with DEB_CYCLES = 4.
module tb_direction_encoder;
`ifdef DIR_REVERSE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    typedef struct {
        logic [3:0] btn;
        logic       tick;
        logic [2:0] dir;
        logic       chg;
        logic       pend;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl [10];
    direction_encoder_if bus ();
    direction_encoder #(.DEB_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set_btn(input logic [3:0] m);
        {bus.btn_d, bus.btn_u, bus.btn_l, bus.btn_r} = m;
    endtask
    task automatic press_release(input logic [3:0] m);
        set_btn(m);
        repeat (8) cyc();
        set_btn(4'd0);
        repeat (8) cyc();
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask
    task automatic do_tick(input string nm, input logic [2:0] d, input logic c, input logic p);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk({nm, "_dir"}, 8'(bus.dir), 8'(d));
        chk({nm, "_chg"}, 8'(bus.dir_changed), 8'(c));
        chk({nm, "_pend"}, 8'(bus.pending), 8'(p));
        cyc();
        chk({nm, "_chg_off"}, 8'(bus.dir_changed), 8'd0);
    endtask
    initial begin
        tbl[0] = '{4'b0100, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[2] = '{4'b0010, 1'b1, LOCK ? 3'd0 : 3'd1, !LOCK, 1'b0};
        tbl[3] = '{4'b1000, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[4] = '{4'b1000, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[5] = '{4'b0100, 1'b1, LOCK ? 3'd3 : 3'd2, !LOCK, 1'b0};
        tbl[6] = '{4'b0001, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[7] = '{4'b0011, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[8] = '{4'b0100, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[9] = '{4'b0000, 1'b1, 3'd2, 1'b1, 1'b0};
        bus.tick = 1'b0;
        set_btn(4'd0);
        #1;
        for (int i = 0; i < 10; i++) begin
            set_btn(4'(i * 5 + 3));
            cyc();
            chk("rst_dir", 8'(bus.dir), 8'd0);
            chk("rst_chg", 8'(bus.dir_changed), 8'd0);
            chk("rst_pend", 8'(bus.pending), 8'd0);
        end
        set_btn(4'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.tick = (i % 10 == 9);
            cyc();
            if (i % 10 == 9) chk("idle_tick_dir", 8'(bus.dir), 8'd0);
        end
        bus.tick = 1'b0;
        bus.btn_u = 1'b1;
        repeat (3) cyc();
        bus.btn_u = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("glitch_pend", 8'(bus.pending), 8'd0);
        end
        bus.btn_u = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            chk($sformatf("deb_pend_%0d", i), 8'(bus.pending), 8'(i == 7));
        end
        do_tick("deb_tick", 3'd2, 1'b1, 1'b0);
        bus.btn_u = 1'b0;
        repeat (8) cyc();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            press_release(tbl[i].btn);
            if (tbl[i].tick) begin
                do_tick($sformatf("vec%0d", i), tbl[i].dir, tbl[i].chg, tbl[i].pend);
            end else begin
                chk($sformatf("vec%0d_dir", i), 8'(bus.dir), 8'(tbl[i].dir));
                chk($sformatf("vec%0d_chg", i), 8'(bus.dir_changed), 8'(tbl[i].chg));
                chk($sformatf("vec%0d_pend", i), 8'(bus.pending), 8'(tbl[i].pend));
            end
        end
        do_reset();
        press_release(4'b0100);
        press_release(4'b1000);
        do_tick("overwrite", 3'd3, 1'b1, 1'b0);
        do_reset();
        press_release(4'b0100);
        bus.btn_d = 1'b1;
        repeat (6) cyc();
        chk("same_pre_pend", 8'(bus.pending), 8'd1);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk("same_dir", 8'(bus.dir), 8'd2);
        chk("same_chg", 8'(bus.dir_changed), 8'd1);
        chk("same_pend", 8'(bus.pending), 8'd1);
        cyc();
        do_tick("same_next", LOCK ? 3'd2 : 3'd3, !LOCK, 1'b0);
        bus.btn_d = 1'b0;
        repeat (8) cyc();
        bus.btn_u = 1'b1;
        repeat (8) cyc();
        chk("async_pre_pend", 8'(bus.pending), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pend", 8'(bus.pending), 8'd0);
        chk("async_dir", 8'(bus.dir), 8'd0);
        chk("async_chg", 8'(bus.dir_changed), 8'd0);
        bus.btn_u = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
